api_slave_mc: RTL and testbench
===============================

API_SLAVE_MC -- requirements
Module: api_slave_mc

Interface
REQ-001 SHALL have parameters (name, default, meaning): CH, 2, API channels (1..8); TXCNT_W, 10, TX count width (1..10); RXCNT_W, 9, RX count width (1..10).
REQ-002 SHALL have ports (name  direction  width  meaning): clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-003 Wishbone: API_CYC_I, API_LOCK_I  in  1, API_CTI_I  in  3, API_BTE_I  in  2, API_SEL_I  in  4, all unused; API_STB_I  in  1; API_WE_I  in  1; API_ADR_I  in  8; API_DAT_I  in  32; API_ACK_O  out  1; API_ERR_O, API_RTY_O  out  1, constant 0; API_DAT_O  out  32.
REQ-004 TX side: txfifo_push  out  CH  per-channel push; txfifo_din  out  32  shared data; txcnt  in  CH*TXCNT_W; txfull  in  CH.
REQ-005 RX side: rxfifo_pop  out  CH; rxfifo_dout  in  CH*32; rxcnt  in  CH*RXCNT_W; rxempty  in  CH.
REQ-006 Control: reg_flush  out  CH; reg_state  in  CH*3; reg_timeout  out  CH*28; reg_sck  out  CH*8; reg_ch_num  out  CH*6; reg_word_num  out  CH*8; irq  out  1. Channel n occupies slice n of every bus.

Function
REQ-007 Decode: ADR[7:5] = channel, ADR[4:0] = offset; 0x00 TXFIFO, 0x04 RXFIFO, 0x08 STATE, 0x0C TIMEOUT, 0x10 SCK, 0x14 IRQCFG.
REQ-008 Qualifying cycle = API_STB_I & ~API_ACK_O; API_ACK_O SHALL be 1 exactly in the following cycle, then 0 (one-cycle pulse, max one access per two cycles).
REQ-009 Read data SHALL be registered on the qualifying edge, valid with ACK; channel >= CH, unknown offset, or TXFIFO read SHALL return 32'hdeaddead; writes there ignored.
REQ-010 TXFIFO write, txfull[n]=0: txfifo_push[n]=1 and txfifo_din=API_DAT_I for the single cycle coincident with ACK.
REQ-011 TXFIFO write, txfull[n]=1: no push; sticky oflow[n] set.
REQ-012 RXFIFO read: rxfifo_pop[n] combinationally high in the qualifying cycle only if rxempty[n]=0, data = rxfifo_dout[n]; if empty: no pop, data 32'hdeaddead, sticky uflow[n] set.
REQ-013 STATE read: [0] txfull, [1] reg_flush, [11:2] txcnt zero-extended, [12] oflow, [15:13] reg_state, [16] rxempty, [17] uflow, [27:18] rxcnt zero-extended, [31:28] 0.
REQ-014 STATE write: DAT[1]=1 drives reg_flush[n] high for exactly 4 cycles starting next cycle; re-write during flush restarts the 4-cycle count; DAT[12]/DAT[17]=1 clear oflow/uflow (W1C); a set event in the same cycle wins.
REQ-015 TIMEOUT: R/W, [27:0] = reg_timeout[n], [31:28] read 0.
REQ-016 SCK: R/W, [7:0] reg_sck, [21:16] reg_ch_num, [31:24] reg_word_num; other bits read 0.
REQ-017 Only the addressed channel SHALL change; others hold.

Reset
REQ-018 On rst: API_ACK_O, txfifo_push, reg_flush, oflow, uflow, irq, all IRQCFG fields = 0; reg_timeout = 28'h0; reg_sck = 8'h04; reg_ch_num = 0; reg_word_num = 0; API_DAT_O = 32'hdeaddead.
REQ-019 rst asserted mid-access SHALL abort it: no push/flush afterwards, ACK 0 next cycle.

Configuration
REQ-020 Macro API_IRQ_EN compiled in: IRQCFG R/W per channel: [9:0] threshold, [16] enable, [24] status (W1C); status set every cycle threshold != 0 and rxcnt >= threshold (set beats clear); irq = OR over channels of status & enable, registered.
REQ-021 Without API_IRQ_EN: IRQCFG reads 0, writes ignored, irq constant 0, no IRQ flops.

Verification
REQ-022 Reset, read SCK ch0 -> 32'h00000004; read TIMEOUT ch1 -> 0; ACK one cycle after STB.
REQ-023 Write TXFIFO ch1 32'h12345678, txfull=0 -> txfifo_push=2'b10 one cycle, txfifo_din=32'h12345678; repeat with txfull[1]=1 -> no push, STATE ch1 bit12=1; write 1<<12 -> bit12=0.
REQ-024 Read RXFIFO ch0, rxempty=1 -> 32'hdeaddead, no pop, STATE bit17=1; rxempty=0, dout=32'hCAFEF00D -> one pop pulse, data 32'hCAFEF00D.
REQ-025 STATE write 32'h2 ch0, re-write 2 cycles later -> reg_flush[0] high 6 cycles total; reg_flush[1] stays 0.
REQ-026 API_IRQ_EN: IRQCFG ch1 = 32'h00010008, rxcnt ch1 7 -> 8 -> irq 1 next cycle; W1C while rxcnt=8 -> status stays 1; rxcnt=3 then W1C -> irq 0.
REQ-027 Read ADR 8'h60 with CH=2 -> 32'hdeaddead; write there -> no output changes.

Source files
------------

// File: rtl/api_slave_mc.sv
// Wishbone register slave for CH API channels: TX/RX FIFO windows, status, flush, timing config.
// Optional per-channel RX-level interrupt logic is compiled in with the API_IRQ_EN macro.
module api_slave_mc #(
    parameter int CH      = 2,
    parameter int TXCNT_W = 10,
    parameter int RXCNT_W = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  API_CYC_I,
    input  logic                  API_LOCK_I,
    input  logic [2:0]            API_CTI_I,
    input  logic [1:0]            API_BTE_I,
    input  logic [3:0]            API_SEL_I,
    input  logic                  API_STB_I,
    input  logic                  API_WE_I,
    input  logic [7:0]            API_ADR_I,
    input  logic [31:0]           API_DAT_I,
    output logic                  API_ACK_O,
    output logic                  API_ERR_O,
    output logic                  API_RTY_O,
    output logic [31:0]           API_DAT_O,
    output logic [CH-1:0]         txfifo_push,
    output logic [31:0]           txfifo_din,
    input  logic [CH*TXCNT_W-1:0] txcnt,
    input  logic [CH-1:0]         txfull,
    output logic [CH-1:0]         rxfifo_pop,
    input  logic [CH*32-1:0]      rxfifo_dout,
    input  logic [CH*RXCNT_W-1:0] rxcnt,
    input  logic [CH-1:0]         rxempty,
    output logic [CH-1:0]         reg_flush,
    input  logic [CH*3-1:0]       reg_state,
    output logic [CH*28-1:0]      reg_timeout,
    output logic [CH*8-1:0]       reg_sck,
    output logic [CH*6-1:0]       reg_ch_num,
    output logic [CH*8-1:0]       reg_word_num,
    output logic                  irq
);
    localparam logic [31:0] DEAD       = 32'hdeaddead;
    localparam logic [4:0]  OFF_TX     = 5'h00;
    localparam logic [4:0]  OFF_RX     = 5'h04;
    localparam logic [4:0]  OFF_STATE  = 5'h08;
    localparam logic [4:0]  OFF_TMO    = 5'h0C;
    localparam logic [4:0]  OFF_SCK    = 5'h10;
    localparam logic [4:0]  OFF_IRQCFG = 5'h14;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d, rdata;
    logic [CH-1:0] push_q, push_d;
    logic [31:0] din_q, din_d;
    logic [2:0]  flush_q [CH];
    logic [2:0]  flush_d [CH];
    logic [CH-1:0] oflow_q, oflow_d, uflow_q, uflow_d;
    logic [27:0] tmo_q [CH];
    logic [27:0] tmo_d [CH];
    logic [7:0]  sck_q [CH];
    logic [7:0]  sck_d [CH];
    logic [5:0]  chn_q [CH];
    logic [5:0]  chn_d [CH];
    logic [7:0]  wrd_q [CH];
    logic [7:0]  wrd_d [CH];
`ifdef API_IRQ_EN
    logic [9:0]  thr_q [CH];
    logic [9:0]  thr_d [CH];
    logic [CH-1:0] en_q, en_d, stat_q, stat_d;
    logic        irq_q, irq_d;
`endif

    logic       qual;
    logic [2:0] ch;
    logic [4:0] off;
    logic       unused_inputs;

    assign unused_inputs = ^{API_CYC_I, API_LOCK_I, API_CTI_I, API_BTE_I, API_SEL_I};
    // Reset kills a qualifying cycle outright, so neither pops nor registered side effects escape.
    assign qual = API_STB_I & ~ack_q & ~rst;
    assign ch   = API_ADR_I[7:5];
    assign off  = API_ADR_I[4:0];

    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise synthesis infers a latch.
        rdata = DEAD;
        for (int n = 0; n < CH; n++) begin
            if (ch == 3'(n)) begin
                case (off)
                    OFF_RX:    if (!rxempty[n]) rdata = rxfifo_dout[n*32 +: 32];
                    OFF_STATE: rdata = {4'b0, 10'(rxcnt[n*RXCNT_W +: RXCNT_W]), uflow_q[n],
                                        rxempty[n], reg_state[n*3 +: 3], oflow_q[n],
                                        10'(txcnt[n*TXCNT_W +: TXCNT_W]), reg_flush[n], txfull[n]};
                    OFF_TMO:   rdata = {4'b0, tmo_q[n]};
                    OFF_SCK:   rdata = {wrd_q[n], 2'b0, chn_q[n], 8'b0, sck_q[n]};
`ifdef API_IRQ_EN
                    OFF_IRQCFG: rdata = {7'b0, stat_q[n], 7'b0, en_q[n], 6'b0, thr_q[n]};
`else
                    OFF_IRQCFG: rdata = 32'h0;
`endif
                    default:   rdata = DEAD;
                endcase
            end
        end
    end

    always_comb begin
        ack_d      = qual;
        dat_d      = qual ? rdata : dat_q;
        push_d     = '0;
        din_d      = din_q;
        rxfifo_pop = '0;
        oflow_d    = oflow_q;
        uflow_d    = uflow_q;
        tmo_d      = tmo_q;
        sck_d      = sck_q;
        chn_d      = chn_q;
        wrd_d      = wrd_q;
`ifdef API_IRQ_EN
        thr_d      = thr_q;
        en_d       = en_q;
        stat_d     = stat_q;
`endif
        for (int n = 0; n < CH; n++) begin
            flush_d[n] = (flush_q[n] != 3'd0) ? flush_q[n] - 3'd1 : 3'd0;
            if (qual && ch == 3'(n) && API_WE_I) begin
                case (off)
                    OFF_TX: begin
                        if (!txfull[n]) begin
                            push_d[n] = 1'b1;
                            din_d     = API_DAT_I;
                        end
                    end
                    OFF_STATE: begin
                        if (API_DAT_I[1])  flush_d[n] = 3'd4;
                        if (API_DAT_I[12]) oflow_d[n] = 1'b0;
                        if (API_DAT_I[17]) uflow_d[n] = 1'b0;
                    end
                    OFF_TMO: tmo_d[n] = API_DAT_I[27:0];
                    OFF_SCK: begin
                        sck_d[n] = API_DAT_I[7:0];
                        chn_d[n] = API_DAT_I[21:16];
                        wrd_d[n] = API_DAT_I[31:24];
                    end
`ifdef API_IRQ_EN
                    OFF_IRQCFG: begin
                        thr_d[n] = API_DAT_I[9:0];
                        en_d[n]  = API_DAT_I[16];
                        if (API_DAT_I[24]) stat_d[n] = 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
            // Set events follow the W1C clears so a coincident set wins.
            if (qual && ch == 3'(n) && API_WE_I && off == OFF_TX && txfull[n]) oflow_d[n] = 1'b1;
            if (qual && ch == 3'(n) && !API_WE_I && off == OFF_RX) begin
                if (!rxempty[n]) rxfifo_pop[n] = 1'b1;
                else             uflow_d[n]    = 1'b1;
            end
`ifdef API_IRQ_EN
            if (thr_q[n] != 10'd0 && 10'(rxcnt[n*RXCNT_W +: RXCNT_W]) >= thr_q[n]) stat_d[n] = 1'b1;
`endif
        end
`ifdef API_IRQ_EN
        irq_d = |(stat_d & en_d);
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            ack_q   <= 1'b0;
            dat_q   <= DEAD;
            push_q  <= '0;
            din_q   <= '0;
            oflow_q <= '0;
            uflow_q <= '0;
            // NOTE: these per-channel arrays are a handful of control flops, not RAM, so resetting them is cheap and required.
            for (int n = 0; n < CH; n++) begin
                flush_q[n] <= 3'd0;
                tmo_q[n]   <= 28'h0;
                sck_q[n]   <= 8'h04;
                chn_q[n]   <= 6'h0;
                wrd_q[n]   <= 8'h0;
`ifdef API_IRQ_EN
                thr_q[n]   <= 10'h0;
`endif
            end
`ifdef API_IRQ_EN
            en_q   <= '0;
            stat_q <= '0;
            irq_q  <= 1'b0;
`endif
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            push_q  <= push_d;
            din_q   <= din_d;
            oflow_q <= oflow_d;
            uflow_q <= uflow_d;
            flush_q <= flush_d;
            tmo_q   <= tmo_d;
            sck_q   <= sck_d;
            chn_q   <= chn_d;
            wrd_q   <= wrd_d;
`ifdef API_IRQ_EN
            thr_q  <= thr_d;
            en_q   <= en_d;
            stat_q <= stat_d;
            irq_q  <= irq_d;
`endif
        end
    end

    always_comb begin
        for (int n = 0; n < CH; n++) begin
            reg_flush[n]             = (flush_q[n] != 3'd0);
            reg_timeout[n*28 +: 28]  = tmo_q[n];
            reg_sck[n*8 +: 8]        = sck_q[n];
            reg_ch_num[n*6 +: 6]     = chn_q[n];
            reg_word_num[n*8 +: 8]   = wrd_q[n];
        end
    end

    assign API_ACK_O   = ack_q;
    assign API_DAT_O   = dat_q;
    assign API_ERR_O   = 1'b0;
    assign API_RTY_O   = 1'b0;
    assign txfifo_push = push_q;
    assign txfifo_din  = din_q;
`ifdef API_IRQ_EN
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_api_slave_mc.sv
// Directed bench for api_slave_mc (CH=2, default widths); IRQ checks follow the API_IRQ_EN build.
module tb_api_slave_mc;
    localparam int CH = 2, TXCNT_W = 10, RXCNT_W = 9;

    logic clk = 1'b0, rst = 1'b1;
    logic stb = 1'b0, we = 1'b0;
    logic [7:0] adr = '0;
    logic [31:0] dat = '0;
    logic ack, err, rty, irq;
    logic [31:0] dat_o, txfifo_din;
    logic [CH-1:0] txfifo_push, rxfifo_pop, reg_flush;
    logic [CH*TXCNT_W-1:0] txcnt = '0;
    logic [CH-1:0] txfull = '0, rxempty = '1;
    logic [CH*32-1:0] rxfifo_dout = '0;
    logic [CH*RXCNT_W-1:0] rxcnt = '0;
    logic [CH*3-1:0] reg_state = '0;
    logic [CH*28-1:0] reg_timeout;
    logic [CH*8-1:0] reg_sck, reg_word_num;
    logic [CH*6-1:0] reg_ch_num;

    int n_vec = 0, n_bad = 0;
    int f0_cnt = 0, f1_cnt = 0;
    logic ack_s;
    logic [CH-1:0] pop_s, push_s;
    logic [31:0] din_s, rd;
    logic [127:0] snap;

    always #5 clk = ~clk;

    api_slave_mc #(.CH(CH), .TXCNT_W(TXCNT_W), .RXCNT_W(RXCNT_W)) dut (
        .clk(clk), .rst(rst),
        .API_CYC_I(stb), .API_LOCK_I(1'b0), .API_CTI_I(3'b0), .API_BTE_I(2'b0), .API_SEL_I(4'hf),
        .API_STB_I(stb), .API_WE_I(we), .API_ADR_I(adr), .API_DAT_I(dat),
        .API_ACK_O(ack), .API_ERR_O(err), .API_RTY_O(rty), .API_DAT_O(dat_o),
        .txfifo_push(txfifo_push), .txfifo_din(txfifo_din), .txcnt(txcnt), .txfull(txfull),
        .rxfifo_pop(rxfifo_pop), .rxfifo_dout(rxfifo_dout), .rxcnt(rxcnt), .rxempty(rxempty),
        .reg_flush(reg_flush), .reg_state(reg_state), .reg_timeout(reg_timeout), .reg_sck(reg_sck),
        .reg_ch_num(reg_ch_num), .reg_word_num(reg_word_num), .irq(irq)
    );

    always @(negedge clk) begin
        if (reg_flush[0]) f0_cnt++;
        if (reg_flush[1]) f1_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus access; the qualifying edge is the posedge after stb rises, ACK is sampled at the next negedge.
    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        stb = 1'b1; we = w; adr = a; dat = d;
        #1 pop_s = rxfifo_pop;
        @(negedge clk);
        ack_s = ack; r = dat_o; push_s = txfifo_push; din_s = txfifo_din;
        check("ack", {127'b0, ack_s}, 128'd1);
        stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", {127'b0, ack}, 128'd0);
        check("rst_dat", {96'b0, dat_o}, {96'b0, 32'hdeaddead});
        check("rst_sck", {112'b0, reg_sck}, {112'b0, 16'h0404});
        check("rst_misc", {reg_timeout, reg_flush, txfifo_push, irq}, 128'd0);
        rst = 1'b0;

        bus(1'b0, 8'h10, 32'h0, rd);
        check("sck0_rd", {96'b0, rd}, {96'b0, 32'h00000004});
        @(negedge clk);
        check("ack_pulse", {127'b0, ack}, 128'd0);
        bus(1'b0, 8'h2C, 32'h0, rd);
        check("tmo1_rd", {96'b0, rd}, 128'd0);

        bus(1'b1, 8'h2C, 32'hFABCDEF1, rd);
        bus(1'b0, 8'h2C, 32'h0, rd);
        check("tmo1_rb", {96'b0, rd}, {96'b0, 32'h0ABCDEF1});
        check("tmo_out", {72'b0, reg_timeout}, {72'b0, 56'hABCDEF1_0000000});
        bus(1'b1, 8'h30, 32'hFFFFFFFF, rd);
        bus(1'b0, 8'h30, 32'h0, rd);
        check("sck1_rb", {96'b0, rd}, {96'b0, 32'hFF3F00FF});
        check("sck_out", {reg_sck, reg_ch_num, reg_word_num}, {88'b0, 16'hFF04, 12'hFC0, 16'hFF00});

        bus(1'b1, 8'h20, 32'h12345678, rd);
        check("push", {126'b0, push_s}, {126'b0, 2'b10});
        check("din", {96'b0, din_s}, {96'b0, 32'h12345678});
        @(negedge clk);
        check("push_end", {126'b0, txfifo_push}, 128'd0);

        txfull = 2'b10; txcnt = {10'h155, 10'h000}; reg_state = {3'b101, 3'b000};
        rxempty = 2'b00; rxcnt = {9'h0AA, 9'h000};
        bus(1'b1, 8'h20, 32'h87654321, rd);
        check("nopush_full", {126'b0, push_s}, 128'd0);
        bus(1'b0, 8'h28, 32'h0, rd);
        check("state1_oflow", {96'b0, rd}, {96'b0, 32'h02A8B555});
        bus(1'b1, 8'h28, 32'h00001000, rd);
        bus(1'b0, 8'h28, 32'h0, rd);
        check("state1_w1c", {96'b0, rd}, {96'b0, 32'h02A8A555});
        txfull = 2'b00;

        rxempty = 2'b11;
        bus(1'b0, 8'h04, 32'h0, rd);
        check("rx_empty_dat", {96'b0, rd}, {96'b0, 32'hdeaddead});
        check("rx_empty_pop", {126'b0, pop_s}, 128'd0);
        bus(1'b0, 8'h08, 32'h0, rd);
        check("state0_uflow", {127'b0, rd[17]}, 128'd1);
        rxempty = 2'b00; rxfifo_dout = {32'h11111111, 32'hCAFEF00D};
        bus(1'b0, 8'h04, 32'h0, rd);
        check("rx_pop", {126'b0, pop_s}, {126'b0, 2'b01});
        check("rx_dat", {96'b0, rd}, {96'b0, 32'hCAFEF00D});
        check("rx_pop_end", {126'b0, rxfifo_pop}, 128'd0);

        bus(1'b0, 8'h00, 32'h0, rd);
        check("tx_read", {96'b0, rd}, {96'b0, 32'hdeaddead});
        bus(1'b0, 8'h18, 32'h0, rd);
        check("bad_off", {96'b0, rd}, {96'b0, 32'hdeaddead});

        f0_cnt = 0; f1_cnt = 0;
        bus(1'b1, 8'h08, 32'h2, rd);
        bus(1'b1, 8'h08, 32'h2, rd);
        repeat (10) @(negedge clk);
        check("flush0_len", 128'(f0_cnt), 128'd6);
        check("flush1_len", 128'(f1_cnt), 128'd0);

        bus(1'b0, 8'h60, 32'h0, rd);
        check("ch_oor_rd", {96'b0, rd}, {96'b0, 32'hdeaddead});
        snap = {reg_timeout, reg_sck, reg_ch_num, reg_word_num, reg_flush, txfifo_push};
        bus(1'b1, 8'h60, 32'hFFFFFFFF, rd);
        bus(1'b1, 8'h68, 32'h00001002, rd);
        @(negedge clk);
        check("ch_oor_wr", {reg_timeout, reg_sck, reg_ch_num, reg_word_num, reg_flush, txfifo_push}, snap);

`ifdef API_IRQ_EN
        rxcnt = {9'd7, 9'd0};
        bus(1'b1, 8'h34, 32'h00010008, rd);
        bus(1'b0, 8'h34, 32'h0, rd);
        check("irqcfg_rb", {96'b0, rd}, {96'b0, 32'h00010008});
        check("irq_below", {127'b0, irq}, 128'd0);
        @(negedge clk); rxcnt = {9'd8, 9'd0};
        @(negedge clk);
        check("irq_set", {127'b0, irq}, 128'd1);
        bus(1'b1, 8'h34, 32'h01000000, rd);
        bus(1'b0, 8'h34, 32'h0, rd);
        check("irq_set_wins", {96'b0, rd}, {96'b0, 32'h01010008});
        check("irq_held", {127'b0, irq}, 128'd1);
        rxcnt = {9'd3, 9'd0};
        bus(1'b1, 8'h34, 32'h01000000, rd);
        check("irq_clr", {127'b0, irq}, 128'd0);
`else
        bus(1'b1, 8'h34, 32'h01010008, rd);
        bus(1'b0, 8'h34, 32'h0, rd);
        check("irqcfg_zero", {96'b0, rd}, 128'd0);
        check("irq_off", {127'b0, irq}, 128'd0);
`endif

        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = 8'h00; dat = 32'hA5A5A5A5; rst = 1'b1;
        @(negedge clk);
        stb = 1'b0; we = 1'b0; rst = 1'b0;
        check("abort_ack", {127'b0, ack}, 128'd0);
        check("abort_push", {126'b0, txfifo_push}, 128'd0);
        @(negedge clk);
        check("abort_after", {126'b0, txfifo_push, ack}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
